lcd_write_sequencer: RTL and testbench



---
 rtl/lcd_write_sequencer_if.sv | 22 ++
 rtl/lcd_write_sequencer.sv | 147 ++++++++++++++
 tb/tb_lcd_write_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_write_sequencer_if.sv
// Bundle between the LSU's LCD output register and the HD44780 panel pins.
// The slave side belongs to lcd_write_sequencer; the master side is the register and the panel.
interface lcd_write_sequencer_if;
  logic [31:0] lcd_word_i;
  logic [7:0]  lcd_data_o;
  logic        lcd_rs_o;
  logic        lcd_rw_o;
  logic        lcd_en_o;
  logic        lcd_on_o;
  logic        busy_o;
  logic        ovf_o;

  modport master (
    output lcd_word_i,
    input  lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, busy_o, ovf_o
  );

  modport slave (
    input  lcd_word_i,
    output lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, busy_o, ovf_o
  );
endinterface

// File: rtl/lcd_write_sequencer.sv
// Timed HD44780 write engine: queues {RS,data} on each strobe rising edge and replays
// every entry to the panel with setup, enable pulse, hold and execution-wait timing.
module lcd_write_sequencer #(
  parameter int DEPTH       = 4,
  parameter int T_SETUP     = 2,
  parameter int T_EN        = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  lcd_write_sequencer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(T_EXEC_LONG + 1);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic [8:0]    r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;

  logic          r_strobe_q;
  logic          r_rs;
  logic [7:0]    r_data;
  logic          r_en;
  logic          r_on;
  logic          r_ovf;

  logic          w_empty;
  logic          w_full;
  logic          w_push_req;
  logic          w_pop;
  logic          w_push;
  logic          w_cnt_zero;
  logic          w_is_long;
  logic [8:0]    w_entry;
  logic [8:0]    w_head;
  logic          w_unused_word;

  assign w_entry    = {bus.lcd_word_i[9], bus.lcd_word_i[7:0]};
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr == {~r_rd_ptr[AW], r_rd_ptr[AW-1:0]});
  assign w_push_req = bus.lcd_word_i[10] & ~r_strobe_q;
  assign w_pop      = (r_state == S_IDLE) & ~w_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_is_long  = ~r_rs & (r_data inside {8'h01, 8'h02, 8'h03});

  assign w_unused_word = ^{bus.lcd_word_i[30:11], bus.lcd_word_i[8]};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - CNT_ONE;
    unique case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = CW'(T_SETUP - 1);
        end
      end
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = CW'(T_EN - 1);
        end
      end
      S_PULSE: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = CW'(T_HOLD - 1);
        end
      end
      S_HOLD: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = w_is_long ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
        end
      end
      S_WAIT: begin
        if (w_cnt_zero) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments, so every register samples the pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_strobe_q <= 1'b0;
      r_rs       <= 1'b0;
      r_data     <= 8'h00;
      r_en       <= 1'b0;
      r_on       <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_strobe_q <= bus.lcd_word_i[10];
      r_on       <= bus.lcd_word_i[31];
      r_en       <= (w_state_nxt == S_PULSE);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_data   <= w_head[7:0];
        r_rs     <= w_head[8];
      end
      if (w_push_req && !w_push) r_ovf <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
  end

  assign bus.lcd_data_o = r_data;
  assign bus.lcd_rs_o   = r_rs;
  assign bus.lcd_rw_o   = 1'b0;
  assign bus.lcd_en_o   = r_en;
  assign bus.lcd_on_o   = r_on;
  assign bus.busy_o     = ~w_empty | (r_state != S_IDLE);
  assign bus.ovf_o      = r_ovf;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: a transaction-level timing model is compared with every output
// on every cycle, and each scenario's literal outcome is also checked directly.
module tb_lcd_write_sequencer;
  localparam int DEPTH = 4;
  localparam int TS    = 1;
  localparam int TE    = 3;
  localparam int TH    = 1;
  localparam int TX    = 5;
  localparam int TL    = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  lcd_write_sequencer_if bus();

  lcd_write_sequencer #(
    .DEPTH(DEPTH), .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TL)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each accepted entry is popped at the first edge where the queue is non-empty and the
  // panel is free; it then owns the panel for setup+pulse+hold+exec cycles plus one idle cycle.
  int         cyc      = 0;
  bit         m_prev   = 1'b0;
  logic [8:0] m_q[$];
  int         m_free   = 0;
  bit         m_have   = 1'b0;
  int         m_pop_at = 0;
  int         m_occ    = 0;
  logic [8:0] m_cur    = 9'h000;
  bit         m_ovf    = 1'b0;
  bit         m_on     = 1'b0;
  bit         m_pop;
  bit         m_req;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_prev = 1'b0;
      m_free = 0;
      m_have = 1'b0;
      m_cur  = 9'h000;
      m_ovf  = 1'b0;
      m_on   = 1'b0;
    end else begin
      cyc++;
      m_pop  = (m_q.size() != 0) && (cyc >= m_free);
      m_req  = bus.lcd_word_i[10] && !m_prev;
      m_prev = bus.lcd_word_i[10];
      m_on   = bus.lcd_word_i[31];
      if (m_pop) begin
        m_cur    = m_q.pop_front();
        m_have   = 1'b1;
        m_pop_at = cyc;
        m_occ    = TS + TE + TH +
                   (((m_cur[8] == 1'b0) && (m_cur[7:0] >= 8'h01) && (m_cur[7:0] <= 8'h03)) ? TL : TX);
        m_free   = cyc + m_occ + 1;
      end
      if (m_req) begin
        if (m_q.size() < DEPTH) m_q.push_back({bus.lcd_word_i[9], bus.lcd_word_i[7:0]});
        else                    m_ovf = 1'b1;
      end
    end
  end

  function automatic logic [31:0] model_out();
    logic en;
    logic busy;
    en   = m_have && (cyc >= m_pop_at + TS) && (cyc < m_pop_at + TS + TE);
    busy = (m_q.size() != 0) || (m_have && (cyc < m_pop_at + m_occ));
    return {18'd0, m_cur[7:0], m_cur[8], 1'b0, en, m_on, busy, m_ovf};
  endfunction

  // Compare process plus a log of every enable pulse seen on the pins.
  logic       prev_en = 1'b0;
  int         cur_len = 0;
  int         rise_q[$];
  int         len_q[$];
  logic [8:0] data_q[$];

  initial forever begin
    @(negedge clk);
    check("cycle_outputs",
          {18'd0, bus.lcd_data_o, bus.lcd_rs_o, bus.lcd_rw_o, bus.lcd_en_o, bus.lcd_on_o,
           bus.busy_o, bus.ovf_o},
          model_out());
    if (bus.lcd_en_o && !prev_en) begin
      rise_q.push_back(cyc);
      data_q.push_back({bus.lcd_rs_o, bus.lcd_data_o});
      cur_len = 0;
    end
    if (bus.lcd_en_o) cur_len++;
    if (!bus.lcd_en_o && prev_en) len_q.push_back(cur_len);
    prev_en = bus.lcd_en_o;
  end

  task automatic clear_log();
    rise_q.delete();
    len_q.delete();
    data_q.delete();
  endtask

  function automatic logic [31:0] fold_data();
    logic [31:0] f;
    f = 32'h0;
    foreach (data_q[i]) f = {f[23:0], data_q[i][7:0]};
    return f;
  endfunction

  // Called at a negedge: one cycle with strobe high, one cycle low.
  task automatic strobe(input logic rs, input logic [7:0] d);
    logic [31:0] w;
    w       = 32'h8000_0400;
    w[9]    = rs;
    w[7:0]  = d;
    bus.lcd_word_i = w;
    @(negedge clk);
    bus.lcd_word_i = 32'h8000_0000;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (bus.busy_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, bus.busy_o, 0);
  endtask

  task automatic wait_en(input string name, input int budget);
    int k;
    k = 0;
    while (!bus.lcd_en_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, bus.lcd_en_o, 1);
  endtask

  initial begin
    logic [15:0] en_v;
    logic [15:0] busy_v;
    logic [7:0]  d_h [16];
    logic        rs_h[16];
    logic        on_h[16];
    int          rst_at;
    logic [31:0] w;

    bus.lcd_word_i = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {18'd0, bus.lcd_data_o, bus.lcd_rs_o, bus.lcd_rw_o, bus.lcd_en_o, bus.lcd_on_o,
           bus.busy_o, bus.ovf_o}, 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single write; index k is the cycle after the k-th posedge, the strobe is sampled at k=1.
    en_v   = '0;
    busy_v = '0;
    bus.lcd_word_i = 32'h8000_0641;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      en_v[k]   = bus.lcd_en_o;
      busy_v[k] = bus.busy_o;
      d_h[k]    = bus.lcd_data_o;
      rs_h[k]   = bus.lcd_rs_o;
      on_h[k]   = bus.lcd_on_o;
      if (k == 1) bus.lcd_word_i = 32'h8000_0000;
    end
    check("single_on",         on_h[1], 1);
    check("single_busy_rise",  busy_v[1], 1);
    check("single_data_early", d_h[1], 8'h00);
    check("single_data",       d_h[2], 8'h41);
    check("single_rs",         rs_h[2], 1);
    check("single_en_window",  en_v, 16'h0038);
    check("single_busy_last",  busy_v[11], 1);
    check("single_busy_fall",  busy_v[12], 0);
    check("single_data_held",  d_h[15], 8'h41);

    // Clear-display command, then a data byte queued behind it.
    clear_log();
    strobe(1'b0, 8'h01);
    strobe(1'b1, 8'h55);
    wait_idle("long_idle", 200);
    check("long_pulses", rise_q.size(), 2);
    if (rise_q.size() == 2 && len_q.size() == 2) begin
      check("long_en_width", len_q[0], TE);
      check("long_gap",      rise_q[1] - rise_q[0], TS + TE + TH + TL + 1);
      check("long_first",    data_q[0], 9'h001);
      check("long_second",   data_q[1], 9'h155);
    end

    // Burst of four writes two cycles apart.
    clear_log();
    for (int i = 0; i < 4; i++) strobe(1'b1, 8'h30 + 8'(i));
    wait_idle("burst_idle", 400);
    check("burst_pulses", rise_q.size(), 4);
    check("burst_order",  fold_data(), 32'h3031_3233);
    check("burst_no_ovf", bus.ovf_o, 0);

    // Overflow: six pushes while a long command sits in its execution wait.
    clear_log();
    strobe(1'b0, 8'h01);
    wait_en("ovf_first_en", 20);
    while (bus.lcd_en_o) @(negedge clk);
    for (int i = 0; i < 6; i++) strobe(1'b1, 8'h60 + 8'(i));
    wait_idle("ovf_idle", 400);
    check("ovf_pulses", rise_q.size(), DEPTH + 1);
    check("ovf_order",  fold_data(), 32'h6061_6263);
    check("ovf_flag",   bus.ovf_o, 1);
    repeat (5) @(negedge clk);
    check("ovf_sticky", bus.ovf_o, 1);

    // Strobe held high for 50 cycles.
    clear_log();
    bus.lcd_word_i = 32'h8000_0477;
    repeat (50) @(negedge clk);
    bus.lcd_word_i = 32'h8000_0000;
    wait_idle("held_idle", 200);
    check("held_pulses", rise_q.size(), 1);
    check("held_data",   fold_data(), 32'h0000_0077);

    // Reset while the enable pulse of a queued write is high.
    strobe(1'b1, 8'hA1);
    strobe(1'b1, 8'hA2);
    strobe(1'b1, 8'hA3);
    wait_en("rst_en_seen", 40);
    #2 rst_n = 1'b0;
    #1;
    check("rst_en_low",   bus.lcd_en_o, 0);
    check("rst_busy_low", bus.busy_o, 0);
    check("rst_regs",     {22'd0, bus.lcd_data_o, bus.lcd_rs_o, bus.ovf_o}, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    clear_log();
    repeat (40) @(negedge clk);
    check("rst_no_pulses", rise_q.size(), 0);
    check("rst_stay_idle", bus.busy_o, 0);

    // Randomised traffic with junk in ignored bits and one asynchronous reset.
    rst_at = int'($urandom_range(300, 1200));
    for (int i = 0; i < 1500; i++) begin
      w     = $urandom;
      w[10] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) begin
        w[9]   = 1'b0;
        w[7:0] = 8'($urandom_range(0, 4));
      end
      bus.lcd_word_i = w;
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    bus.lcd_word_i = 32'h0;
    wait_idle("random_idle", 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
